// File: rtl/bool_pkg.sv
// Shared types and sizing helpers for the boolean-stage bit packer.
package bool_pkg;

    typedef enum logic {
        STATE_FILL = 1'b0,
        STATE_FULL = 1'b1
    } packer_state_t;

    localparam int NBITS_DEFAULT = 8;

    // Ones-count width must hold the value NBITS itself, hence NBITS+1 codes.
    function automatic int ones_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/bool_bit_packer_if.sv
// Sample-in / word-out handshake bundle for bool_bit_packer.
interface bool_bit_packer_if
    import bool_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
);
    localparam int CW = ones_width(NBITS);

    logic             in_val;
    logic             in_rdy;
    logic             in_f;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_data;
    logic [CW-1:0]    out_ones;

    // master: upstream sample source plus downstream word sink
    modport master (
        output in_val, in_f, out_rdy,
        input  in_rdy, out_val, out_data, out_ones
    );

    modport slave (
        input  in_val, in_f, out_rdy,
        output in_rdy, out_val, out_data, out_ones
    );

endinterface

// File: rtl/bool_bit_packer.sv
// Packs NBITS consecutive samples of the boolean stage output f into one word, LSB first,
// and hands the word plus its ones-count downstream.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// STATE_FILL | collecting samples; out_data/out_ones show the partial word
// STATE_FULL | complete word presented on out_val; new sample only if drained
module bool_bit_packer
    import bool_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    bool_bit_packer_if.slave bus
);
    localparam int CW    = ones_width(NBITS);
    localparam int CNT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(NBITS - 1);

    packer_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [NBITS-1:0] word_r, word_nxt;
    logic [CW-1:0]    ones_r, ones_nxt;
    logic             in_xfer;
    logic             out_xfer;

    assign bus.in_rdy   = (state == STATE_FILL) | bus.out_rdy;
    assign bus.out_val  = (state == STATE_FULL);
    assign bus.out_data = word_r;
    assign bus.out_ones = ones_r;

    assign in_xfer  = bus.in_val & bus.in_rdy;
    assign out_xfer = bus.out_val & bus.out_rdy;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word_r;
        ones_nxt  = ones_r;

        unique case (state)
            STATE_FILL: begin
                if (in_xfer) begin
                    word_nxt[cnt] = bus.in_f;
                    ones_nxt      = ones_r + CW'(bus.in_f);
                    if (cnt == LAST_POS) begin
                        cnt_nxt   = '0;
                        state_nxt = STATE_FULL;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            STATE_FULL: begin
                // A sample arriving while the word drains starts the next word at bit 0.
                if (out_xfer) begin
                    state_nxt = STATE_FILL;
                    if (in_xfer) begin
                        word_nxt = NBITS'(bus.in_f);
                        ones_nxt = CW'(bus.in_f);
                        cnt_nxt  = CNT_W'(1);
                    end else begin
                        word_nxt = '0;
                        ones_nxt = '0;
                        cnt_nxt  = '0;
                    end
                end
            end
            default: state_nxt = STATE_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= STATE_FILL;
            cnt    <= '0;
            word_r <= '0;
            ones_r <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            word_r <= word_nxt;
            ones_r <= ones_nxt;
        end
    end

endmodule

// File: tb/tb_bool_bit_packer.sv
// Bench for bool_bit_packer (NBITS=8): directed scenarios plus random traffic against a
// queue-based model of accepted samples and completed words.
module tb_bool_bit_packer;

    logic clk;
    logic reset_n;

    bool_bit_packer_if #(.NBITS(8)) bus ();

    bool_bit_packer #(.NBITS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit         acc[$];
    logic [7:0] words[$];

    logic       exp_val, exp_rdy;
    logic [7:0] exp_data;
    int         exp_ones;
    logic       obs_val, obs_rdy;
    logic [7:0] obs_data;
    logic [3:0] obs_ones;

    function automatic logic [7:0] pack_acc();
        logic [7:0] w = '0;
        foreach (acc[i]) w[i] = acc[i];
        return w;
    endfunction

    // One clock: drive inputs, sample outputs mid-cycle, then advance the model.
    task automatic tick(input logic v, input logic f, input logic r);
        bus.in_val  = v;
        bus.in_f    = f;
        bus.out_rdy = r;
        @(negedge clk);
        obs_val  = bus.out_val;
        obs_rdy  = bus.in_rdy;
        obs_data = bus.out_data;
        obs_ones = bus.out_ones;
        exp_val  = (words.size() != 0);
        exp_rdy  = !exp_val || r;
        exp_data = exp_val ? words[0] : pack_acc();
        exp_ones = $countones(exp_data);
        if (exp_val && r) void'(words.pop_front());
        if (v && exp_rdy) begin
            acc.push_back(f);
            if (acc.size() == 8) begin
                words.push_back(pack_acc());
                acc.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n, input logic v, input logic f);
        reset_n     = 1'b0;
        bus.in_val  = v;
        bus.in_f    = f;
        bus.out_rdy = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
        acc.delete();
        words.delete();
    endtask

    task automatic test_reset();
        apply_reset(2, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_rdy !== 1'b1 || obs_val !== 1'b0 || obs_data !== 8'h00 || obs_ones !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b val=%b data=%h ones=%0d, need rdy=1 val=0 data=00 ones=0",
                     obs_rdy, obs_val, obs_data, obs_ones);
        end
    endtask

    task automatic test_basic_pack();
        bit pat[8] = '{1, 0, 1, 1, 0, 0, 0, 1};
        apply_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, pat[i], 1'b1);
            checks++;
            if (obs_val !== 1'b0 || obs_rdy !== 1'b1) begin
                failures++;
                $display("FAIL basic_fill[%0d]: val=%b rdy=%b, need val=0 rdy=1", i, obs_val, obs_rdy);
            end
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_val !== 1'b1 || obs_data !== 8'h8D || obs_ones !== 4'd4 || obs_data !== exp_data) begin
            failures++;
            $display("FAIL basic_word: val=%b data=%h ones=%0d, need val=1 data=8d ones=4",
                     obs_val, obs_data, obs_ones);
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_val !== 1'b0) begin
            failures++;
            $display("FAIL basic_drop: val=%b, need 0", obs_val);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1, 1'b0, 1'b0);
        repeat (8) tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_rdy !== 1'b0 || obs_val !== 1'b1 || obs_data !== 8'hFF || obs_ones !== 4'd8) begin
                failures++;
                $display("FAIL bp_hold[%0d]: rdy=%b val=%b data=%h ones=%0d, need rdy=0 val=1 data=ff ones=8",
                         i, obs_rdy, obs_val, obs_data, obs_ones);
            end
        end
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_rdy !== 1'b1 || obs_val !== 1'b1 || obs_data !== 8'hFF) begin
            failures++;
            $display("FAIL bp_drain: rdy=%b val=%b data=%h, need rdy=1 val=1 data=ff", obs_rdy, obs_val, obs_data);
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_val !== 1'b0 || obs_data !== 8'h01 || obs_ones !== 4'd1) begin
            failures++;
            $display("FAIL bp_carry: val=%b data=%h ones=%0d, need val=0 data=01 ones=1",
                     obs_val, obs_data, obs_ones);
        end
    endtask

    task automatic test_back_to_back();
        int seen[$];
        apply_reset(1, 1'b0, 1'b0);
        for (int t = 0; t < 18; t++) begin
            tick(t < 16, ((t % 2) == 0), 1'b1);
            if (t < 16) begin
                checks++;
                if (obs_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_stall[%0d]: rdy=%b, need 1", t, obs_rdy);
                end
            end
            if (obs_val === 1'b1) begin
                seen.push_back(t);
                checks++;
                if (obs_data !== 8'h55 || obs_ones !== 4'd4) begin
                    failures++;
                    $display("FAIL b2b_word@%0d: data=%h ones=%0d, need data=55 ones=4", t, obs_data, obs_ones);
                end
            end
        end
        checks++;
        if (seen.size() != 2 || seen[0] != 8 || seen[1] != 16) begin
            failures++;
            $display("FAIL b2b_timing: words=%0d first=%0d second=%0d, need 2 words at 8 and 16",
                     seen.size(), (seen.size() > 0) ? seen[0] : -1, (seen.size() > 1) ? seen[1] : -1);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset(1, 1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b1, 1'b1);
        apply_reset(1, 1'b1, 1'b1);
        repeat (8) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_val !== 1'b1 || obs_data !== 8'h00 || obs_ones !== 4'd0) begin
            failures++;
            $display("FAIL midreset_word: val=%b data=%h ones=%0d, need val=1 data=00 ones=0",
                     obs_val, obs_data, obs_ones);
        end
    endtask

    task automatic test_gaps();
        apply_reset(1, 1'b0, 1'b0);
        for (int abc = 0; abc < 8; abc++) begin
            tick(1'b1, (abc == 2) || (abc == 7), 1'b1);
            tick(1'b0, 1'($urandom), 1'b1);
        end
        checks++;
        if (obs_val !== 1'b1 || obs_data !== 8'h84 || obs_ones !== 4'd2) begin
            failures++;
            $display("FAIL gaps_word: val=%b data=%h ones=%0d, need val=1 data=84 ones=2",
                     obs_val, obs_data, obs_ones);
        end
    endtask

    task automatic test_random();
        apply_reset(1, 1'b0, 1'b0);
        for (int t = 0; t < 400; t++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (obs_val !== exp_val || obs_rdy !== exp_rdy || obs_data !== exp_data || obs_ones !== 4'(exp_ones)) begin
                failures++;
                $display("FAIL rand[%0d]: val=%b rdy=%b data=%h ones=%0d, need val=%b rdy=%b data=%h ones=%0d",
                         t, obs_val, obs_rdy, obs_data, obs_ones, exp_val, exp_rdy, exp_data, exp_ones);
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.in_val  = 1'b0;
        bus.in_f    = 1'b0;
        bus.out_rdy = 1'b0;
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_gaps();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
